rv32_rf_wb_arbiter: RTL and testbench
=====================================

RV32_RF_WB_ARBITER -- requirements
Module: rv32_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive ALU-denied cycles before the ALU is force-granted (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: alu_wb_valid  input  1; alu_wb_rd  input  5; alu_wb_data  input  32; these form the ALU writeback request.
REQ-005 SHALL have port: alu_wb_ready  output  1  ALU request accepted this cycle when high with alu_wb_valid.
REQ-006 SHALL have ports: ld_wb_valid  input  1; ld_wb_rd  input  5; ld_wb_data  input  32; these form the load-return writeback request.
REQ-007 SHALL have port: ld_wb_ready  output  1  load request accepted this cycle when high with ld_wb_valid.
REQ-008 SHALL have ports: iss_valid  input  1; iss_rs1  input  5; iss_rs2  input  5; iss_rd  input  5; iss_is_load  input  1; these describe the decode-stage instruction being issued.
REQ-009 SHALL have port: iss_stall  output  1  combinational hazard stall to decode.
REQ-010 SHALL have ports: write_reg  output  1; sel_d1  output  5; reg_d1  output  32; these form the registered drive to the register-file write port.

Function
REQ-011 SHALL accept at most one request per cycle; a request is accepted when valid && ready are both high in the same cycle.
REQ-012 SHALL use a two-state FSM: LD_PRI (load wins when both requesters are valid) and ALU_FORCE (ALU wins, ld_wb_ready=0).
REQ-013 SHALL count consecutive cycles with alu_wb_valid=1 and alu_wb_ready=0; when the count reaches STARVE_LIMIT, the FSM SHALL move LD_PRI->ALU_FORCE.
REQ-014 SHALL return ALU_FORCE->LD_PRI after exactly one cycle; the counter SHALL clear on any ALU acceptance or on any cycle with alu_wb_valid=0.
REQ-015 SHALL grant the sole valid requester in either state; if none is valid, both readies are high and nothing is accepted.
REQ-016 SHALL register the accepted request: write_reg, sel_d1 and reg_d1 are valid in the cycle after acceptance (latency 1); write_reg=0 otherwise.
REQ-017 SHALL accept an accepted request with rd=0 normally but SHALL NOT assert write_reg for it.
REQ-018 SHALL hold a 32-bit busy scoreboard; busy[0] is hardwired to 0.
REQ-019 SHALL set busy[iss_rd] on issue of a load: iss_valid && !iss_stall && iss_is_load && iss_rd!=0.
REQ-020 SHALL clear busy[ld_wb_rd] on load acceptance; if the same cycle also sets the same index, the set SHALL win.
REQ-021 SHALL assert iss_stall when iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]), i.e. RAW and WAW on a pending load.
REQ-022 SHALL NOT stall on busy state being cleared in the current cycle; the register-file bypass covers same-cycle write/read.
REQ-023 SHALL ignore ALU writebacks for scoreboard purposes; ALU ordering is the pipeline's responsibility.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force: FSM=LD_PRI, starve counter=0, busy=0, write_reg=0, sel_d1=0, reg_d1=0.
REQ-025 SHALL discard any in-flight accepted request on reset mid-operation; no write_reg pulse after reset release until a new acceptance.
REQ-026 SHALL drive alu_wb_ready=1, ld_wb_ready=1 and iss_stall=0 in the first cycle after reset when inputs are idle.

Structure
REQ-027 SHALL import shared package rv32_rf_pkg containing: XLEN=32, the reg_idx_t (5-bit) typedef, and the wb_arb_state_t enum {LD_PRI, ALU_FORCE}.
REQ-028 SHALL instantiate one sub-module, rv32_rf_scoreboard, holding the busy vector and its set/clear/stall logic; arbitration and FSM stay in the top.

Verification
REQ-029 SHALL cover: ALU only, rd=5, data 0xDEADBEEF -> alu_wb_ready=1; next cycle write_reg=1, sel_d1=5, reg_d1=0xDEADBEEF.
REQ-030 SHALL cover: both valid continuously with STARVE_LIMIT=4 -> loads granted 4 cycles, ALU granted cycle 5 with ld_wb_ready=0, then loads resume.
REQ-031 SHALL cover: issue load rd=7, then issue rs1=7 -> iss_stall=1 until ld_wb accepted for rd=7; stall drops the following cycle.
REQ-032 SHALL cover: same cycle load issue rd=9 and load writeback rd=9 accepted -> busy[9] stays 1; load issue with rd=0 -> no busy bit set.
REQ-033 SHALL cover: ld_wb rd=0, data 0x1234 -> ld_wb_ready=1, write_reg stays 0.
REQ-034 SHALL cover: rst_n pulled low mid-stream with busy[3]=1 and a pending accepted write -> all outputs 0 and busy=0 immediately; no stale write after release.

Source files
------------

// File: rtl/rv32_rf_pkg.sv
// ============================================================================
// rv32_rf_pkg : shared types for the register-file writeback arbiter slice
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32_rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [0:0] {
        LD_PRI    = 1'b0,
        ALU_FORCE = 1'b1
    } wb_arb_state_t;

    function automatic logic [NREGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_rf_scoreboard.sv
// ============================================================================
// rv32_rf_scoreboard : pending-load busy vector with RAW/WAW issue stall
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32_rf_scoreboard
    import rv32_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iss_valid,
    input  logic [4:0] iss_rs1,
    input  logic [4:0] iss_rs2,
    input  logic [4:0] iss_rd,
    input  logic       iss_is_load,
    input  logic       ld_acc,
    input  logic [4:0] ld_rd,
    output logic       iss_stall
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             busy_set;

    // Stall looks only at the registered vector; a clear landing this cycle
    // is covered by the register-file bypass on the following cycle.
    assign iss_stall = iss_valid &&
                       (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);

    always_comb begin
        busy_set = iss_valid && !iss_stall && iss_is_load && (iss_rd != 5'd0);
        busy_d   = busy_q;
        if (ld_acc) begin
            busy_d = busy_d & ~idx_onehot(ld_rd);
        end
        // Set after clear so a same-index issue keeps the bit busy.
        if (busy_set) begin
            busy_d = busy_d | idx_onehot(iss_rd);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32_rf_wb_arbiter.sv
// ============================================================================
// rv32_rf_wb_arbiter : ALU / load writeback arbiter with starvation guard,
//                      registered register-file write port and load scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32_rf_wb_arbiter
    import rv32_rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            ld_wb_valid,
    input  logic [4:0]      ld_wb_rd,
    input  logic [XLEN-1:0] ld_wb_data,
    output logic            ld_wb_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic [4:0]      iss_rd,
    input  logic            iss_is_load,
    output logic            iss_stall,
    output logic            write_reg,
    output logic [4:0]      sel_d1,
    output logic [XLEN-1:0] reg_d1
);

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    wb_arb_state_t   state_q,      state_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            write_reg_q,  write_reg_d;
    logic [4:0]      sel_d1_q,     sel_d1_d;
    logic [XLEN-1:0] reg_d1_q,     reg_d1_d;
    logic            alu_acc;
    logic            ld_acc;

    always_comb begin
        alu_wb_ready = 1'b1;
        ld_wb_ready  = 1'b1;
        // The preferred side is always ready; the other only when it is alone.
        if (state_q == LD_PRI) begin
            alu_wb_ready = !ld_wb_valid;
        end else begin
            ld_wb_ready  = !alu_wb_valid;
        end
        alu_acc = alu_wb_valid && alu_wb_ready;
        ld_acc  = ld_wb_valid  && ld_wb_ready;

        starve_cnt_d = (alu_wb_valid && !alu_wb_ready) ? starve_cnt_q + 4'd1 : 4'd0;
        state_d      = ((state_q == LD_PRI) && (starve_cnt_d == C_LIMIT)) ? ALU_FORCE : LD_PRI;

        write_reg_d = 1'b0;
        sel_d1_d    = sel_d1_q;
        reg_d1_d    = reg_d1_q;
        if (ld_acc) begin
            write_reg_d = (ld_wb_rd != 5'd0);
            sel_d1_d    = ld_wb_rd;
            reg_d1_d    = ld_wb_data;
        end else if (alu_acc) begin
            write_reg_d = (alu_wb_rd != 5'd0);
            sel_d1_d    = alu_wb_rd;
            reg_d1_d    = alu_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_PRI;
            starve_cnt_q <= 4'd0;
            write_reg_q  <= 1'b0;
            sel_d1_q     <= 5'd0;
            reg_d1_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            write_reg_q  <= write_reg_d;
            sel_d1_q     <= sel_d1_d;
            reg_d1_q     <= reg_d1_d;
        end
    end

    assign write_reg = write_reg_q;
    assign sel_d1    = sel_d1_q;
    assign reg_d1    = reg_d1_q;

    rv32_rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rd      (iss_rd),
        .iss_is_load (iss_is_load),
        .ld_acc      (ld_acc),
        .ld_rd       (ld_wb_rd),
        .iss_stall   (iss_stall)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv32_rf_wb_arbiter.sv
// ============================================================================
// tb_rv32_rf_wb_arbiter : table-driven bench with a writeback scoreboard queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wb_valid, ld_wb_valid, iss_valid, iss_is_load;
    logic [4:0]  alu_wb_rd, ld_wb_rd, iss_rs1, iss_rs2, iss_rd;
    logic [31:0] alu_wb_data, ld_wb_data;
    logic        alu_wb_ready, ld_wb_ready, iss_stall, write_reg;
    logic [4:0]  sel_d1;
    logic [31:0] reg_d1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32_rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .ld_wb_valid  (ld_wb_valid),
        .ld_wb_rd     (ld_wb_rd),
        .ld_wb_data   (ld_wb_data),
        .ld_wb_ready  (ld_wb_ready),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .iss_is_load  (iss_is_load),
        .iss_stall    (iss_stall),
        .write_reg    (write_reg),
        .sel_d1       (sel_d1),
        .reg_d1       (reg_d1)
    );

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_data;
        logic        iss_v;
        logic [4:0]  rs1, rs2, rd;
        logic        is_ld;
        logic        e_alu_rdy, e_ld_rdy, e_stall;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    vec_t tbl[$];
    wb_t  exp_q[$];

    function automatic void addv(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] wd, input logic il,
                                 input logic ea, input logic el, input logic es);
        vec_t v;
        v.alu_v = av; v.alu_rd = ard; v.alu_data = ad;
        v.ld_v = lv;  v.ld_rd = lrd;  v.ld_data = ldat;
        v.iss_v = iv; v.rs1 = r1; v.rs2 = r2; v.rd = wd; v.is_ld = il;
        v.e_alu_rdy = ea; v.e_ld_rdy = el; v.e_stall = es;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h expected=0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_wb_valid = v.alu_v; alu_wb_rd = v.alu_rd; alu_wb_data = v.alu_data;
        ld_wb_valid  = v.ld_v;  ld_wb_rd  = v.ld_rd;  ld_wb_data  = v.ld_data;
        iss_valid    = v.iss_v; iss_rs1   = v.rs1;    iss_rs2     = v.rs2;
        iss_rd       = v.rd;    iss_is_load = v.is_ld;
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wb_t w, got;
        drive(v);
        @(negedge clk);
        chk("alu_wb_ready", idx, {31'd0, alu_wb_ready}, {31'd0, v.e_alu_rdy});
        chk("ld_wb_ready",  idx, {31'd0, ld_wb_ready},  {31'd0, v.e_ld_rdy});
        chk("iss_stall",    idx, {31'd0, iss_stall},    {31'd0, v.e_stall});
        w = '{default: '0};
        if (v.ld_v && v.e_ld_rdy) begin
            w.we = (v.ld_rd != 5'd0); w.rd = v.ld_rd; w.data = v.ld_data;
        end else if (v.alu_v && v.e_alu_rdy) begin
            w.we = (v.alu_rd != 5'd0); w.rd = v.alu_rd; w.data = v.alu_data;
        end
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("write_reg", idx, {31'd0, write_reg}, {31'd0, got.we});
        if (got.we) begin
            chk("sel_d1", idx, {27'd0, sel_d1}, {27'd0, got.rd});
            chk("reg_d1", idx, reg_d1, got.data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Both valid, ALU rd 10, load rd 11
        addv(0,0,0,          0,0,0,          0,0,0,0,0,   1,1,0); // 0 idle
        addv(1,5,32'hDEADBEEF, 0,0,0,        0,0,0,0,0,   1,1,0); // 1 ALU only
        addv(0,0,0,          1,0,32'h1234,   0,0,0,0,0,   0,1,0); // 2 load rd0
        for (int i = 0; i < 4; i++)
            addv(1,10,32'hA0+i, 1,11,32'hB0+i, 0,0,0,0,0, 0,1,0); // 3-6 load wins
        addv(1,10,32'hA4,    1,11,32'hB4,    0,0,0,0,0,   1,0,0); // 7 ALU forced
        addv(1,10,32'hA5,    1,11,32'hB5,    0,0,0,0,0,   0,1,0); // 8 loads resume
        addv(0,0,0,          1,11,32'hB6,    0,0,0,0,0,   0,1,0); // 9 ALU idle clears count
        for (int i = 0; i < 4; i++)
            addv(1,10,32'hC0+i, 1,11,32'hD0+i, 0,0,0,0,0, 0,1,0); // 10-13
        addv(1,10,32'hC4,    1,11,32'hD4,    0,0,0,0,0,   1,0,0); // 14 forced
        addv(0,0,0,          0,0,0,          0,0,0,0,0,   1,1,0); // 15
        addv(0,0,0,          0,0,0,          1,1,2,7,1,   1,1,0); // 16 issue load rd7
        addv(0,0,0,          0,0,0,          1,7,0,8,0,   1,1,1); // 17 RAW stall
        addv(0,0,0,          1,7,32'h77,     1,7,0,8,0,   0,1,1); // 18 still stalled
        addv(0,0,0,          0,0,0,          1,7,0,8,0,   1,1,0); // 19 stall drops
        addv(0,0,0,          1,9,32'h99,     1,0,0,9,1,   0,1,0); // 20 set beats clear
        addv(0,0,0,          0,0,0,          1,0,9,1,0,   1,1,1); // 21 busy9 held
        addv(0,0,0,          0,0,0,          1,2,3,9,1,   1,1,1); // 22 WAW stall
        addv(0,0,0,          1,9,32'h999,    0,0,0,0,0,   0,1,0); // 23 clear 9
        addv(0,0,0,          0,0,0,          1,9,0,0,1,   1,1,0); // 24 load rd0
        addv(0,0,0,          0,0,0,          1,0,0,0,0,   1,1,0); // 25
        addv(0,0,0,          0,0,0,          1,0,0,12,1,  1,1,0); // 26 load rd12
        addv(0,0,0,          0,0,0,          0,12,0,0,0,  1,1,0); // 27 not valid
        addv(0,0,0,          0,0,0,          1,0,12,3,0,  1,1,1); // 28
        addv(1,13,32'h1313,  1,12,32'hC12,   0,0,0,0,0,   0,1,0); // 29
        addv(0,0,0,          0,0,0,          1,12,0,3,0,  1,1,0); // 30
        addv(0,0,0,          0,0,0,          1,0,0,14,1,  1,1,0); // 31 load rd14
        addv(1,14,32'hE,     0,0,0,          1,14,0,2,0,  1,1,1); // 32 ALU rd14
        addv(0,0,0,          0,0,0,          1,14,0,2,0,  1,1,1); // 33 ALU didn't clear
        addv(0,0,0,          1,14,32'hE14,   0,0,0,0,0,   0,1,0); // 34
        addv(0,0,0,          0,0,0,          1,14,0,2,0,  1,1,0); // 35

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_write_reg", -1, {31'd0, write_reg}, 32'd0);
        chk("rst_sel_d1",    -1, {27'd0, sel_d1},    32'd0);
        chk("rst_reg_d1",    -1, reg_d1,             32'd0);
        chk("rst_busy",      -1, dut.u_scoreboard.busy_q, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Reset mid-stream: busy[3] set, a write showing, another accepted in flight
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd4; alu_wb_data = 32'h44;
        iss_valid = 1'b1; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd3; iss_is_load = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_write_reg", 100, {31'd0, write_reg}, 32'd1);
        chk("pre_rst_busy",      100, dut.u_scoreboard.busy_q, 32'h0000_0008);
        idle_inputs();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd6; alu_wb_data = 32'h66;
        @(negedge clk);
        chk("inflight_alu_rdy", 101, {31'd0, alu_wb_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write_reg", 102, {31'd0, write_reg}, 32'd0);
        chk("mid_rst_sel_d1",    102, {27'd0, sel_d1},    32'd0);
        chk("mid_rst_reg_d1",    102, reg_d1,             32'd0);
        chk("mid_rst_busy",      102, dut.u_scoreboard.busy_q, 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_write_reg", 103, {31'd0, write_reg}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        iss_valid = 1'b1; iss_rs1 = 5'd3; iss_rd = 5'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_alu_rdy", 104 + c, {31'd0, alu_wb_ready}, 32'd1);
            chk("post_rst_ld_rdy",  104 + c, {31'd0, ld_wb_ready},  32'd1);
            chk("post_rst_stall",   104 + c, {31'd0, iss_stall},    32'd0);
            @(posedge clk);
            #1;
            chk("post_rst_write_reg", 104 + c, {31'd0, write_reg}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
